// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU op bit indices, HI/LO op encoding and bus widths.
// The decode-to-execute bundle type lives here too.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_W     = 5;
    localparam int ALU_OP_W  = 12;
    localparam int HILO_OP_W = 4;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // one-hot {mflo, mfhi, mtlo, mthi}
    localparam int HILO_MTHI = 0;
    localparam int HILO_MTLO = 1;
    localparam int HILO_MFHI = 2;
    localparam int HILO_MFLO = 3;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        word_t                src1;
        word_t                src2;
        logic [REG_W-1:0]     dest;
        word_t                pc;
        logic                 ov_chk;
        logic [HILO_OP_W-1:0] hilo_op;
    } ds_to_es_t;

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: decode->execute offer, execute->memory payload and
// the bypass tag back to decode. slave = execute stage side.
interface exe_stage_if;
    import cpu_pkg::*;

    logic                 ds_to_es_valid;
    logic                 es_allowin;
    logic [ALU_OP_W-1:0]  ds_alu_op;
    word_t                ds_src1;
    word_t                ds_src2;
    logic [REG_W-1:0]     ds_dest;
    word_t                ds_pc;
    logic                 ds_ov_chk;
    logic [HILO_OP_W-1:0] ds_hilo_op;
    logic                 ms_allowin;
    logic                 flush;
    logic                 es_to_ms_valid;
    word_t                es_result;
    logic [REG_W-1:0]     es_dest;
    word_t                es_pc;
    logic                 es_ex;
    logic [REG_W-1:0]     es_fwd_dest;

    modport master (
        output ds_to_es_valid, ds_alu_op, ds_src1, ds_src2,
        output ds_dest, ds_pc, ds_ov_chk, ds_hilo_op,
        output ms_allowin, flush,
        input  es_allowin, es_to_ms_valid, es_result,
        input  es_dest, es_pc, es_ex, es_fwd_dest
    );

    modport slave (
        input  ds_to_es_valid, ds_alu_op, ds_src1, ds_src2,
        input  ds_dest, ds_pc, ds_ov_chk, ds_hilo_op,
        input  ms_allowin, flush,
        output es_allowin, es_to_ms_valid, es_result,
        output es_dest, es_pc, es_ex, es_fwd_dest
    );

endinterface

// File: rtl/exe_stage_alu.sv
// alu: one-hot op ALU; add/sub/slt/sltu share a single adder.
// alu_overflow is the signed overflow of add/sub only.
import cpu_pkg::*;

module alu (
    input  logic [ALU_OP_W-1:0] alu_op,
    input  word_t               alu_src1,
    input  word_t               alu_src2,
    output word_t               alu_result,
    output logic                alu_overflow
);

    logic          is_sub;
    word_t         add_b;
    logic [XLEN:0] add_sum;
    logic          slt_r;
    logic          sltu_r;

    assign is_sub = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
    assign add_b  = is_sub ? ~alu_src2 : alu_src2;
    assign add_sum = {1'b0, alu_src1} + {1'b0, add_b}
                   + {{XLEN{1'b0}}, is_sub};

    assign slt_r = (alu_src1[XLEN-1] & ~alu_src2[XLEN-1])
                 | (~(alu_src1[XLEN-1] ^ alu_src2[XLEN-1])
                    & add_sum[XLEN-1]);
    assign sltu_r = ~add_sum[XLEN];

    assign alu_overflow = (alu_op[ALU_ADD] | alu_op[ALU_SUB])
                        & (alu_src1[XLEN-1] == add_b[XLEN-1])
                        & (add_sum[XLEN-1] != alu_src1[XLEN-1]);

    // result mux; an all-zero op (reset bubble) yields zero
    always_comb begin
        alu_result = '0;
        case (1'b1)
            alu_op[ALU_ADD],
            alu_op[ALU_SUB]:  alu_result = add_sum[XLEN-1:0];
            alu_op[ALU_SLT]:  alu_result = {{(XLEN-1){1'b0}}, slt_r};
            alu_op[ALU_SLTU]: alu_result = {{(XLEN-1){1'b0}}, sltu_r};
            alu_op[ALU_AND]:  alu_result = alu_src1 & alu_src2;
            alu_op[ALU_NOR]:  alu_result = ~(alu_src1 | alu_src2);
            alu_op[ALU_OR]:   alu_result = alu_src1 | alu_src2;
            alu_op[ALU_XOR]:  alu_result = alu_src1 ^ alu_src2;
            alu_op[ALU_SLL]:  alu_result = alu_src2 << alu_src1[4:0];
            alu_op[ALU_SRL]:  alu_result = alu_src2 >> alu_src1[4:0];
            alu_op[ALU_SRA]:  alu_result = $signed(alu_src2) >>> alu_src1[4:0];
            alu_op[ALU_LUI]:  alu_result = {alu_src2[15:0], 16'h0000};
            default:          alu_result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: single-cycle execute stage with overflow trap and HI/LO.
// HI/LO registers and mfhi/mflo/mthi/mtlo exist only with EXE_HILO_EN.
import cpu_pkg::*;

module exe_stage (
    input  logic         clk,
    input  logic         resetn,
    exe_stage_if.slave   io
);

    logic                 es_valid;
    logic                 es_ready_go;
    logic                 es_allowin;
    logic                 es_ex;
    ds_to_es_t            es_q;
    logic [HILO_OP_W-1:0] hilo_in;
    word_t                alu_result;
    logic                 alu_overflow;

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & io.ms_allowin);

`ifdef EXE_HILO_EN
    assign hilo_in = io.ds_hilo_op;
`else
    assign hilo_in = '0;
`endif

    // stage valid and latched decode bundle; flush wins over everything
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
            es_q     <= '0;
        end else if (io.flush) begin
            es_valid <= 1'b0;
        end else if (io.ds_to_es_valid && es_allowin) begin
            es_valid <= 1'b1;
            es_q     <= '{alu_op:  io.ds_alu_op,
                          src1:    io.ds_src1,
                          src2:    io.ds_src2,
                          dest:    io.ds_dest,
                          pc:      io.ds_pc,
                          ov_chk:  io.ds_ov_chk,
                          hilo_op: hilo_in};
        end else if (io.ms_allowin) begin
            es_valid <= 1'b0;
        end
    end

    alu u_alu (
        .alu_op       (es_q.alu_op),
        .alu_src1     (es_q.src1),
        .alu_src2     (es_q.src2),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    assign es_ex = es_valid & es_q.ov_chk & alu_overflow;

`ifdef EXE_HILO_EN
    word_t hi_q;
    word_t lo_q;
    logic  hilo_we;

    // commit only on the handoff edge so a stalled move writes once
    assign hilo_we = es_valid & io.ms_allowin & ~io.flush & ~es_ex;

    // HI/LO architectural registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            if (es_q.hilo_op[HILO_MTHI]) hi_q <= es_q.src1;
            if (es_q.hilo_op[HILO_MTLO]) lo_q <= es_q.src1;
        end
    end

    // move-from selects HI/LO instead of the ALU
    always_comb begin
        io.es_result = alu_result;
        if (es_q.hilo_op[HILO_MFHI]) io.es_result = hi_q;
        else if (es_q.hilo_op[HILO_MFLO]) io.es_result = lo_q;
    end
`else
    assign io.es_result = alu_result;
`endif

    assign io.es_allowin     = es_allowin;
    assign io.es_to_ms_valid = es_valid & es_ready_go & ~io.flush;
    assign io.es_ex          = es_ex;
    assign io.es_dest        = es_ex ? '0 : es_q.dest;
    assign io.es_pc          = es_q.pc;
    assign io.es_fwd_dest    = es_valid ? io.es_dest : '0;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage; reference ALU and HI/LO
// model follow EXE_HILO_EN the same way the design does.
module tb_exe_stage;
    import cpu_pkg::*;

    typedef struct {
        word_t      res;
        logic [4:0] dest;
        logic       ex;
        word_t      pc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exe_stage_if io();

    exe_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (io.slave)
    );

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mv = 1'b0;
    bit         accepted = 1'b0;
    word_t      mhi = '0;
    word_t      mlo = '0;
    logic [3:0] c_hilo = '0;
    word_t      c_src1 = '0;
    logic       c_ex = 1'b0;
    logic [4:0] c_dest = '0;
    word_t      pc = 32'h1000_0000;
    int         n;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void alu_ref(input logic [11:0] op, input word_t a,
                                    input word_t b, output word_t r,
                                    output logic ov);
        logic [32:0] s;
        r = '0;
        ov = 1'b0;
        s = '0;
        if (op[ALU_ADD]) begin
            s = {a[31], a} + {b[31], b};
            r = s[31:0];
            ov = s[32] ^ s[31];
        end else if (op[ALU_SUB]) begin
            s = {a[31], a} - {b[31], b};
            r = s[31:0];
            ov = s[32] ^ s[31];
        end else if (op[ALU_SLT]) r = ($signed(a) < $signed(b)) ? 1 : 0;
        else if (op[ALU_SLTU]) r = (a < b) ? 1 : 0;
        else if (op[ALU_AND]) r = a & b;
        else if (op[ALU_NOR]) r = ~(a | b);
        else if (op[ALU_OR]) r = a | b;
        else if (op[ALU_XOR]) r = a ^ b;
        else if (op[ALU_SLL]) r = b << a[4:0];
        else if (op[ALU_SRL]) r = b >> a[4:0];
        else if (op[ALU_SRA]) r = $signed(b) >>> a[4:0];
        else if (op[ALU_LUI]) r = {b[15:0], 16'h0};
    endfunction

    task automatic reset_checks();
        check("rst_allowin", io.es_allowin, 1);
        check("rst_to_ms_valid", io.es_to_ms_valid, 0);
        check("rst_ex", io.es_ex, 0);
        check("rst_dest", io.es_dest, 0);
        check("rst_fwd_dest", io.es_fwd_dest, 0);
        check("rst_result", io.es_result, 0);
    endtask

    // compare current outputs with the model, then advance the model
    task automatic step_model();
        bit    allow;
        bit    commit;
        exp_t  e;
        word_t r;
        logic  ov;
        allow = !mv || io.ms_allowin;
        check("allowin", io.es_allowin, allow);
        check("to_ms_valid", io.es_to_ms_valid, mv && !io.flush);
        check("fwd_dest", io.es_fwd_dest, mv ? c_dest : 5'd0);
        if (mv) begin
            check("sb_occupancy", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                check("result", io.es_result, sb[0].res);
                check("dest", io.es_dest, sb[0].dest);
                check("ex", io.es_ex, sb[0].ex);
                check("pc", io.es_pc, sb[0].pc);
            end
        end
        commit = mv && io.ms_allowin && !io.flush;
        if (mv && (commit || io.flush) && sb.size() != 0)
            e = sb.pop_front();
`ifdef EXE_HILO_EN
        if (commit && !c_ex) begin
            if (c_hilo[HILO_MTHI]) mhi = c_src1;
            if (c_hilo[HILO_MTLO]) mlo = c_src1;
        end
`endif
        accepted = 1'b0;
        if (io.flush) mv = 1'b0;
        else if (io.ds_to_es_valid && allow) begin
            alu_ref(io.ds_alu_op, io.ds_src1, io.ds_src2, r, ov);
            e.ex = io.ds_ov_chk && ov;
            e.res = r;
`ifdef EXE_HILO_EN
            if (io.ds_hilo_op[HILO_MFHI]) e.res = mhi;
            else if (io.ds_hilo_op[HILO_MFLO]) e.res = mlo;
`endif
            e.dest = e.ex ? 5'd0 : io.ds_dest;
            e.pc = io.ds_pc;
            sb.push_back(e);
            mv = 1'b1;
            c_hilo = io.ds_hilo_op;
            c_src1 = io.ds_src1;
            c_ex = e.ex;
            c_dest = e.dest;
            accepted = 1'b1;
        end else if (io.ms_allowin) mv = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ds(input int k, input word_t a, input word_t b,
                          input logic [4:0] d, input logic ovc,
                          input logic [3:0] h);
        io.ds_alu_op = 12'(1) << k;
        io.ds_src1 = a;
        io.ds_src2 = b;
        io.ds_dest = d;
        io.ds_pc = pc;
        io.ds_ov_chk = ovc;
        io.ds_hilo_op = h;
        io.ds_to_es_valid = 1'b1;
        pc = pc + 4;
    endtask

    task automatic offer(input int k, input word_t a, input word_t b,
                         input logic [4:0] d, input logic ovc,
                         input logic [3:0] h, output int cyc);
        set_ds(k, a, b, d, ovc, h);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!accepted && cyc < 20);
        check("offer_accepted", accepted, 1);
    endtask

    task automatic model_reset();
        mv = 1'b0;
        mhi = '0;
        mlo = '0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        io.ds_to_es_valid = 1'b0;
        io.ds_alu_op = '0;
        io.ds_src1 = '0;
        io.ds_src2 = '0;
        io.ds_dest = '0;
        io.ds_pc = '0;
        io.ds_ov_chk = 1'b0;
        io.ds_hilo_op = '0;
        io.ms_allowin = 1'b1;
        io.flush = 1'b0;
        #2;
        reset_checks();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // signed overflow trap, then the same add without checking
        offer(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 4'h0, n);
        offer(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b0, 4'h0, n);

        // slt/sltu issued back to back
        offer(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b0, 4'h0, n);
        check("b2b_slt_cycles", n, 1);
        offer(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b0, 4'h0, n);
        check("b2b_sltu_cycles", n, 1);

        // downstream stall for three cycles with a new offer waiting
        offer(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, 5'd9, 1'b0, 4'h0, n);
        io.ms_allowin = 1'b0;
        set_ds(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd10, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_latch", accepted, 0);
        end
        io.ms_allowin = 1'b1;
        tick();
        check("stall_release_latch", accepted, 1);

        // mthi/mfhi and mtlo/mflo
        offer(ALU_ADD, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 4'b0001, n);
        offer(ALU_ADD, 32'h3, 32'h4, 5'd7, 1'b0, 4'b0100, n);
        offer(ALU_ADD, 32'hCAFE_0001, 32'h0, 5'd0, 1'b0, 4'b0010, n);
        offer(ALU_SUB, 32'h9, 32'h2, 5'd8, 1'b0, 4'b1000, n);

        // flush of a stalled mthi: HI must keep its old value
        offer(ALU_ADD, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 4'b0001, n);
        io.ds_to_es_valid = 1'b0;
        io.ms_allowin = 1'b0;
        tick();
        io.flush = 1'b1;
        tick();
        io.flush = 1'b0;
        tick();
        io.ms_allowin = 1'b1;
        offer(ALU_ADD, 32'h5, 32'h6, 5'd11, 1'b0, 4'b0100, n);

        // reset while a mtlo is stalled
        offer(ALU_ADD, 32'h0000_0055, 32'h0, 5'd0, 1'b0, 4'b0010, n);
        io.ds_to_es_valid = 1'b0;
        io.ms_allowin = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        io.ms_allowin = 1'b1;
        @(posedge clk);
        #1;
        offer(ALU_OR, 32'h1, 32'h2, 5'd12, 1'b0, 4'b0100, n);
        offer(ALU_OR, 32'h4, 32'h8, 5'd13, 1'b0, 4'b1000, n);

        // random traffic with back-pressure and occasional flush
        for (int i = 0; i < 200; i++) begin
            logic [3:0] h;
            h = ($urandom_range(0, 3) == 0) ?
                4'(1 << $urandom_range(0, 3)) : 4'h0;
            set_ds($urandom_range(0, 11), $urandom, $urandom,
                   5'($urandom), 1'($urandom), h);
            if ($urandom_range(0, 3) == 0) io.ds_src1 = 32'h7FFF_FFFF;
            io.ds_to_es_valid = 1'($urandom_range(0, 3) != 0);
            io.ms_allowin = 1'($urandom_range(0, 3) != 0);
            io.flush = 1'($urandom_range(0, 15) == 0);
            tick();
        end

        io.ds_to_es_valid = 1'b0;
        io.ms_allowin = 1'b1;
        io.flush = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have ds_to_es_valid, input, 1, decode-stage instruction offered.
REQ-004 SHALL have es_allowin, output, 1, this stage accepts an instruction this cycle.
REQ-005 SHALL have ds_alu_op/ds_src1/ds_src2, input, 12/32/32, ALU one-hot op and operands.
REQ-006 SHALL have ds_dest/ds_pc, input, 5/32, GPR destination (0 = none) and PC.
REQ-007 SHALL have ds_ov_chk, input, 1, instruction traps on signed overflow (ADD/ADDI/SUB).
REQ-008 SHALL have ds_hilo_op, input, 4, one-hot {mflo, mfhi, mtlo, mthi}; 0 = none.
REQ-009 SHALL have ms_allowin, input, 1, memory stage accepts.
REQ-010 SHALL have flush, input, 1, writeback exception flush.
REQ-011 SHALL have es_to_ms_valid/es_result/es_dest/es_pc/es_ex, output, 1/32/5/32/1, downstream payload.
REQ-012 SHALL have es_fwd_dest, output, 5, bypass/stall tag to decode.

Function
REQ-013 SHALL hold es_valid; es_ready_go is constant 1 (single-cycle execute).
REQ-014 SHALL drive es_allowin = !es_valid | ms_allowin.
REQ-015 SHALL latch all ds_* fields and set es_valid on ds_to_es_valid & es_allowin; otherwise clear es_valid when ms_allowin; otherwise hold.
REQ-016 SHALL give flush top priority: es_valid cleared at next edge, no latch that cycle.
REQ-017 SHALL drive es_to_ms_valid = es_valid & !flush.
REQ-018 SHALL feed latched op/operands to the ALU combinationally; es_result valid same cycle as es_valid.
REQ-019 SHALL drive es_ex = es_valid & ov_chk & alu_overflow.
REQ-020 SHALL force es_dest = 0 when es_ex = 1 (no GPR write on trap).
REQ-021 SHALL select es_result = HI on mfhi, LO on mflo, else ALU result.
REQ-022 SHALL write HI (mthi) / LO (mtlo) with latched src1 only when es_valid & ms_allowin & !flush & !es_ex; exactly once per instruction.
REQ-023 SHALL drive es_fwd_dest = es_valid ? es_dest : 0.
REQ-024 SHALL hold all payload outputs stable while es_valid & !ms_allowin.

Reset
REQ-025 SHALL on resetn low immediately clear es_valid, all latched fields, HI, LO; outputs: es_allowin 1, es_to_ms_valid 0, es_ex 0, es_dest 0, es_fwd_dest 0, es_result 0.
REQ-026 SHALL discard an in-flight instruction on reset mid-operation with no HI/LO update.

Configuration
REQ-027 SHALL compile HI/LO support under macro EXE_HILO_EN.
REQ-028 SHALL with EXE_HILO_EN defined implement REQ-021/022; without it, no HI/LO registers, ds_hilo_op ignored, es_result = ALU result.

Structure
REQ-029 SHALL take ALU op bit indices, hilo_op encoding and bus widths from shared package cpu_pkg.
REQ-030 SHALL instantiate the existing alu block as its only sub-module.

Verification
REQ-031 SHALL check: add, src1 0x7FFFFFFF, src2 0x1, ov_chk 1, dest 5 -> es_ex 1, es_dest 0; ov_chk 0 -> es_result 0x80000000, es_dest 5.
REQ-032 SHALL check: ms_allowin 0 for 3 cycles with es_valid -> es_allowin 0, outputs unchanged, new ds offer not latched; accepted cycle after ms_allowin 1.
REQ-033 SHALL check: mthi src1 0x12345678 then mfhi -> es_result 0x12345678 (EXE_HILO_EN); without macro -> ALU result.
REQ-034 SHALL check: flush during mthi stall -> es_to_ms_valid 0 same cycle, es_valid 0 next, HI unchanged.
REQ-035 SHALL check: resetn low mid-stall -> es_valid, HI, LO 0 before next clock edge; es_allowin 1.
REQ-036 SHALL check: slt src1 0xFFFFFFFF, src2 0x1 -> es_result 0x1; sltu same -> 0x0; back-to-back issue, no bubbles.
